if_fetch_stage: RTL
===================

Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage pipelined CPU.
- Owns the PC and drives the instruction-memory address; the memory returns data combinationally in the same cycle.
- Registers the fetched word into the IF/ID pipeline register consumed by the decode stage.
- Honours stall from the hazard unit and branch redirect from the branch-resolution logic, and stops fetching at a HALT encoding.

Parameters:
- ADDR_W, 64, width of the PC and all instruction addresses.
- INSTR_W, 32, width of an instruction word.
- RESET_PC, 0, PC value loaded by reset.
- HALT_INSTR, 32'hD4400000, encoding that halts fetch.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  hazard unit: hold PC and IF/ID.
- redirect  in  1  taken branch / mispredict: load redirect_target.
- redirect_target  in  ADDR_W  new fetch address.
- imem_addr  out  ADDR_W  instruction-memory address; equals pc.
- imem_rdata  in  INSTR_W  instruction word at imem_addr, same cycle.
- ifid_pc  out  ADDR_W  PC of the instruction held in IF/ID.
- ifid_instr  out  INSTR_W  instruction held in IF/ID.
- ifid_valid  out  1  IF/ID holds a real instruction (0 = bubble).
- halted  out  1  fetch is stopped in S_HALT.

Behaviour:
- Reset (asynchronous, active-high): pc=RESET_PC, ifid_pc=0, ifid_instr=0, ifid_valid=0, halted=0, state=S_BOOT.
- imem_addr = pc, combinational.
- FSM states:
  - S_BOOT: exactly one cycle after reset deasserts. No fetch; IF/ID stays a bubble; pc holds. Next state S_RUN. A redirect in S_BOOT loads pc=redirect_target and still goes to S_RUN.
  - S_RUN: per-cycle priority is redirect > stall > advance.
  - S_HALT: pc holds; IF/ID is a bubble (ifid_valid=0, ifid_instr=0); halted=1. Only redirect (to S_RUN, pc=target, halted=0) or reset leaves it. stall is ignored in S_HALT.
- Redirect (any state):
  - pc <= {redirect_target[ADDR_W-1:2],2'b00}, i.e. low two bits forced to zero.
  - IF/ID <= bubble: valid=0, instr=0, ifid_pc unchanged.
  - Redirect wins over a simultaneous stall; the fetched word is discarded.
- Stall (no redirect, S_RUN): pc, ifid_pc, ifid_instr and ifid_valid all hold.
- Advance (S_RUN, no redirect, no stall):
  - pc <= pc+4, wrapping modulo 2^ADDR_W (no overflow flag).
  - ifid_pc <= pc; ifid_instr <= imem_rdata; ifid_valid <= 1.
- HALT detection:
  - On an advance with imem_rdata==HALT_INSTR, the HALT word is still latched into IF/ID with valid=1 so it retires.
  - pc does NOT increment; the FSM enters S_HALT.
  - A HALT word arriving during stall or redirect is not acted on.
- Latency: an instruction fetched in cycle N is visible on ifid_* after the rising edge ending cycle N, i.e. one-cycle latency.
- Reset asserted mid-operation overrides everything immediately, including stall, redirect and S_HALT.

Optional Feature:
- Macro IF_PERF_CNT_EN.
- When defined, adds two output ports:
  - fetch_count (32 bits): increments on every advance, including the HALT fetch.
  - bubble_count (32 bits): increments on every cycle the stage writes a bubble (S_BOOT, redirect, S_HALT) or holds for stall.
- Both counters reset to 0, saturate at 32'hFFFFFFFF and are never cleared except by reset.
- When not defined, the ports and logic are absent and all other behaviour is identical.

Test Plan:
- Reset then free-run, imem returns 32'h91000421 at every address:
  - cycle after S_BOOT: imem_addr=0, then 4, 8, 12 on successive cycles.
  - ifid_valid rises one cycle after the first fetch, with ifid_pc=0.
- Stall held for 3 cycles at pc=8: pc stays 8; ifid_pc/instr/valid unchanged for 3 cycles; on release the next ifid_pc is 8.
- Redirect with target 64'h103 while stall=1 at pc=12: next cycle pc=64'h100 and ifid_valid=0; the following cycle ifid_pc=64'h100.
- imem returns HALT_INSTR at pc=16:
  - ifid_instr=HALT_INSTR with valid=1 for one cycle, then valid=0.
  - halted=1 and pc stays 16 indefinitely; a later redirect to 0 restarts fetch with halted=0.
- Wrap: redirect to 64'hFFFFFFFFFFFFFFFC, then advance: next pc=0 and ifid_pc=64'hFFFFFFFFFFFFFFFC.
- Assert reset asynchronously mid-clock while in S_RUN at pc=40: outputs go to reset values before the next clock edge; S_BOOT repeats before fetch resumes at 0.

Source files
------------

// File: rtl/if_fetch_stage.sv
// ============================================================================
// if_fetch_stage
// ----------------------------------------------------------------------------
// Instruction-fetch stage of a 5-stage pipelined CPU.
//
// This stage owns the program counter and presents it directly to the
// instruction memory. The memory returns its word combinationally in the same
// cycle, and the stage registers that word into the IF/ID pipeline register.
//
// Each cycle the stage does one of the following, in priority order:
//   redirect : Load the aligned redirect target into the PC and put a bubble
//              into IF/ID. This wins over stall and over every state.
//   boot     : In the first cycle after reset, do not fetch. IF/ID stays a
//              bubble.
//   halt     : After a HALT word retires, keep the PC and keep putting
//              bubbles into IF/ID until a redirect arrives.
//   stall    : Hold the PC and IF/ID unchanged.
//   advance  : Latch the fetched word into IF/ID and step the PC by 4. If
//              the word is HALT, the PC stays where it is and the stage
//              enters S_HALT.
//
// Optional feature, enabled by the macro IF_PERF_CNT_EN:
//   This adds the saturating 32-bit counters fetch_count and bubble_count.
//   fetch_count counts advances. bubble_count counts bubble cycles and stall
//   hold cycles.
// ============================================================================

module if_fetch_stage #(
  parameter int unsigned          ADDR_W     = 64,
  parameter int unsigned          INSTR_W    = 32,
  parameter logic [ADDR_W-1:0]    RESET_PC   = '0,
  parameter logic [INSTR_W-1:0]   HALT_INSTR = 32'hD4400000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                redirect,
  input  logic [ADDR_W-1:0]   redirect_target,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic [INSTR_W-1:0]  imem_rdata,
  output logic [ADDR_W-1:0]   ifid_pc,
  output logic [INSTR_W-1:0]  ifid_instr,
  output logic                ifid_valid,
  output logic                halted
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]         fetch_count,
  output logic [31:0]         bubble_count
`endif
);

  // --------------------------------------------------------------------------
  // Types and state
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    pc_q, pc_d;
  logic [ADDR_W-1:0]    ifid_pc_q, ifid_pc_d;
  logic [INSTR_W-1:0]   ifid_instr_q, ifid_instr_d;
  logic                 ifid_valid_q, ifid_valid_d;

  // Per-cycle event strobes. These feed the optional counters and help
  // when reading waveforms.
  logic                 advance;
  logic                 hold_or_bubble;

  // Aligned redirect target. Instructions are word aligned, so the two
  // low bits of the target are dropped.
  logic [ADDR_W-1:0]    redirect_pc;
  logic                 unused_target_lsbs;

  assign redirect_pc        = {redirect_target[ADDR_W-1:2], 2'b00};
  assign unused_target_lsbs = ^redirect_target[1:0];

  // --------------------------------------------------------------------------
  // Next-state and IF/ID update logic
  // --------------------------------------------------------------------------
  // Choose one action for this cycle (redirect > boot/halt > stall > advance).
  always_comb begin
    // NOTE: every signal assigned in this block gets a default value first.
    // Without the defaults, a path that leaves a signal unassigned would make
    // synthesis infer a latch.
    state_d        = state_q;
    pc_d           = pc_q;
    ifid_pc_d      = ifid_pc_q;
    ifid_instr_d   = ifid_instr_q;
    ifid_valid_d   = ifid_valid_q;
    advance        = 1'b0;
    hold_or_bubble = 1'b0;

    if (redirect) begin
      // Redirect from any state. The word fetched this cycle is discarded,
      // and ifid_pc keeps the PC of the last real instruction.
      pc_d           = redirect_pc;
      ifid_instr_d   = '0;
      ifid_valid_d   = 1'b0;
      state_d        = S_RUN;
      hold_or_bubble = 1'b1;
    end else begin
      unique case (state_q)
        S_BOOT: begin
          // First cycle out of reset: no fetch, and IF/ID stays a bubble.
          ifid_instr_d   = '0;
          ifid_valid_d   = 1'b0;
          state_d        = S_RUN;
          hold_or_bubble = 1'b1;
        end

        S_RUN: begin
          if (stall) begin
            // The hazard unit holds PC and IF/ID exactly as they are.
            hold_or_bubble = 1'b1;
          end else begin
            advance      = 1'b1;
            ifid_pc_d    = pc_q;
            ifid_instr_d = imem_rdata;
            ifid_valid_d = 1'b1;
            if (imem_rdata == HALT_INSTR) begin
              // The HALT word still retires. Fetch freezes on its address.
              state_d = S_HALT;
            end else begin
              // The PC wraps naturally modulo 2^ADDR_W.
              pc_d = pc_q + ADDR_W'(4);
            end
          end
        end

        S_HALT: begin
          // Stall is ignored here. Only a redirect or reset leaves this
          // state.
          ifid_instr_d   = '0;
          ifid_valid_d   = 1'b0;
          hold_or_bubble = 1'b1;
        end

        default: begin
          state_d = S_BOOT;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // State, PC and IF/ID registers
  // --------------------------------------------------------------------------
  // Register the state, PC and IF/ID. Reset is asynchronous.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: use non-blocking assignments for sequential state, so that every
    // register samples its next value from the pre-edge values.
    if (reset) begin
      state_q      <= S_BOOT;
      pc_q         <= RESET_PC;
      ifid_pc_q    <= '0;
      ifid_instr_q <= '0;
      ifid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign imem_addr  = pc_q;
  assign ifid_pc    = ifid_pc_q;
  assign ifid_instr = ifid_instr_q;
  assign ifid_valid = ifid_valid_q;
  assign halted     = (state_q == S_HALT);

`ifdef IF_PERF_CNT_EN
  // --------------------------------------------------------------------------
  // Optional saturating performance counters
  // --------------------------------------------------------------------------
  logic [31:0] fetch_count_q;
  logic [31:0] bubble_count_q;

  // Count advances and bubble/hold cycles. Each counter sticks at all-ones
  // and is cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_count_q  <= '0;
      bubble_count_q <= '0;
    end else begin
      if (advance && (fetch_count_q != 32'hFFFF_FFFF)) begin
        fetch_count_q <= fetch_count_q + 32'd1;
      end
      if (hold_or_bubble && (bubble_count_q != 32'hFFFF_FFFF)) begin
        bubble_count_q <= bubble_count_q + 32'd1;
      end
    end
  end

  assign fetch_count  = fetch_count_q;
  assign bubble_count = bubble_count_q;
`endif

endmodule
